// File: rtl/freq_gate_ctrl.sv
// ---------------------------------------------------------------------------
// freq_gate_ctrl
//
// Measurement sequencer for a 6-digit BCD event counter in a frequency meter.
// Each measurement runs four phases:
//   CLEAR  - holds the counter's clear input high
//   GATE   - enables the counter for a fixed window of reference clocks
//   SETTLE - waits for the counter's own clock domain to settle
//   LATCH  - copies the counter value into RESULT and pulses VALID
// With START held high, measurements repeat back-to-back. Each measurement
// takes CLR_CYCLES + GATE_CYCLES + SETTLE_CYCLES + 1 clocks.
//
// Ports:
//   CLK       in   reference clock, rising edge
//   CLR       in   synchronous active-high reset, overrides every other input
//   START     in   level: high = measure continuously, low = stop when done
//   ABORT     in   drop the current measurement and return to IDLE
//   CNT_Q     in   24-bit BCD count from the counter (nibble 0 = units)
//   CNT_CLR   out  clear to the counter (high during CLEAR)
//   CNT_ENA   out  enable to the counter (high during GATE)
//   RESULT    out  last latched BCD count
//   VALID     out  one-cycle pulse in the LATCH cycle that updates RESULT
//   BUSY      out  high in every state except IDLE
//   MEAS_CNT  out  completed measurement count, wraps 255 -> 0
//   BCD_ERR   out  (FREQ_GATE_CTRL_BCD_CHECK_EN only) set when the last
//                  LATCH saw a nibble above 9
//
// Optional feature macro: FREQ_GATE_CTRL_BCD_CHECK_EN
//   When this macro is defined, an illegal BCD digit at LATCH blocks the
//   RESULT/VALID/MEAS_CNT update and raises BCD_ERR. BCD_ERR stays high until
//   a later LATCH sees a legal value.
// ---------------------------------------------------------------------------
module freq_gate_ctrl #(
    parameter int GATE_CYCLES   = 8,   // 1..65535
    parameter int CLR_CYCLES    = 2,   // 1..255
    parameter int SETTLE_CYCLES = 3    // 1..255
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic        ABORT,
    input  logic [23:0] CNT_Q,
    output logic        CNT_CLR,
    output logic        CNT_ENA,
    output logic [23:0] RESULT,
    output logic        VALID,
    output logic        BUSY,
    output logic [7:0]  MEAS_CNT
`ifdef FREQ_GATE_CTRL_BCD_CHECK_EN
    ,
    output logic        BCD_ERR
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_LATCH
    } state_t;

    localparam logic [15:0] CLR_LOAD    = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] GATE_LOAD   = 16'(GATE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [23:0] result_q, result_d;
    logic [7:0]  meas_cnt_q, meas_cnt_d;
    logic        bcd_err_q, bcd_err_d;
    logic        valid;
    logic        timer_done;
    logic        bcd_ok;

    // The timer is loaded with N-1 on entering a state. The state advances on
    // the cycle the timer reads 0, so each state lasts exactly N cycles.
    function automatic logic [15:0] timer_load(input state_t s);
        case (s)
            S_CLEAR:  timer_load = CLR_LOAD;
            S_GATE:   timer_load = GATE_LOAD;
            S_SETTLE: timer_load = SETTLE_LOAD;
            default:  timer_load = 16'd0;
        endcase
    endfunction

    assign timer_done = (timer_q == 16'd0);

`ifdef FREQ_GATE_CTRL_BCD_CHECK_EN
    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (CNT_Q[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
        end
    end
`else
    assign bcd_ok = 1'b1;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        result_d   = result_q;
        meas_cnt_d = meas_cnt_q;
        bcd_err_d  = bcd_err_q;
        valid      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // If ABORT and START are both high in IDLE, stay in IDLE.
                if (START && !ABORT) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (ABORT)           state_d = S_IDLE;
                else if (timer_done) state_d = S_GATE;
            end
            S_GATE: begin
                if (ABORT)           state_d = S_IDLE;
                else if (timer_done) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (ABORT)           state_d = S_IDLE;
                else if (timer_done) state_d = S_LATCH;
            end
            S_LATCH: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    if (bcd_ok) begin
                        result_d   = CNT_Q;
                        meas_cnt_d = meas_cnt_q + 8'd1;
                        valid      = 1'b1;
                    end
                    bcd_err_d = !bcd_ok;
                    state_d   = START ? S_CLEAR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every state change goes to a different state, so a state change
        // always means a state entry and reloads the timer.
        if (state_d != state_q) timer_d = timer_load(state_d);
        else if (!timer_done)   timer_d = timer_q - 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            result_q   <= 24'h000000;
            meas_cnt_q <= 8'd0;
            bcd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            result_q   <= result_d;
            meas_cnt_q <= meas_cnt_d;
            bcd_err_q  <= bcd_err_d;
        end
    end

    // These outputs are decoded straight from the state register.
    assign CNT_CLR  = (state_q == S_CLEAR);
    assign CNT_ENA  = (state_q == S_GATE);
    assign BUSY     = (state_q != S_IDLE);
    assign VALID    = valid;
    assign RESULT   = result_q;
    assign MEAS_CNT = meas_cnt_q;

`ifdef FREQ_GATE_CTRL_BCD_CHECK_EN
    assign BCD_ERR = bcd_err_q;
`else
    // Without the check, bcd_err_q stays at its reset value and drives no port.
    logic unused_bcd_err;
    assign unused_bcd_err = bcd_err_q;
`endif

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_gate_ctrl
//
// Directed self-checking bench for freq_gate_ctrl with default parameters
// (CLR 2, GATE 8, SETTLE 3: one measurement every 14 cycles).
// Cycle k = 1 is the first cycle in CLEAR after START is sampled in IDLE.
//   CLEAR   k = 1..2
//   GATE    k = 3..10
//   SETTLE  k = 11..13
//   LATCH   k = 14 (VALID is high in this cycle)
// RESULT and MEAS_CNT show the new values from k = 15.
// ---------------------------------------------------------------------------
module tb_freq_gate_ctrl;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        START;
    logic        ABORT;
    logic [23:0] CNT_Q;
    logic        CNT_CLR;
    logic        CNT_ENA;
    logic [23:0] RESULT;
    logic        VALID;
    logic        BUSY;
    logic [7:0]  MEAS_CNT;
`ifdef FREQ_GATE_CTRL_BCD_CHECK_EN
    logic        BCD_ERR;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    freq_gate_ctrl dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .START    (START),
        .ABORT    (ABORT),
        .CNT_Q    (CNT_Q),
        .CNT_CLR  (CNT_CLR),
        .CNT_ENA  (CNT_ENA),
        .RESULT   (RESULT),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .MEAS_CNT (MEAS_CNT)
`ifdef FREQ_GATE_CTRL_BCD_CHECK_EN
        ,
        .BCD_ERR  (BCD_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge, then settle 1 time unit before sampling
    // outputs or driving inputs.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int phase;
        int n_valid;

        CLR   = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        CNT_Q = 24'h000000;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_cnt_clr",  32'(CNT_CLR),  32'd0);
        check("rst_cnt_ena",  32'(CNT_ENA),  32'd0);
        check("rst_valid",    32'(VALID),    32'd0);
        check("rst_busy",     32'(BUSY),     32'd0);
        check("rst_result",   32'(RESULT),   32'h0);
        check("rst_meas_cnt", 32'(MEAS_CNT), 32'd0);
        CLR = 1'b0;
        step();
        check("idle_busy", 32'(BUSY), 32'd0);

        // ---------------- two back-to-back measurements ----------------
        CNT_Q = 24'h001234;
        START = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step();
            phase = (k - 1) % 14;
            check($sformatf("b2b_clr_k%0d", k),   32'(CNT_CLR), 32'(phase < 2));
            check($sformatf("b2b_ena_k%0d", k),   32'(CNT_ENA), 32'(phase >= 2 && phase < 10));
            check($sformatf("b2b_valid_k%0d", k), 32'(VALID),   32'(phase == 13));
            check($sformatf("b2b_busy_k%0d", k),  32'(BUSY),    32'd1);
            if (k == 15) begin
                check("b2b_result_1",   32'(RESULT),   32'h001234);
                check("b2b_meas_cnt_1", 32'(MEAS_CNT), 32'd1);
            end
        end
        // START is dropped during the second LATCH, so the sequencer returns
        // to IDLE after it.
        START = 1'b0;
        step();
        check("b2b_end_busy",     32'(BUSY),     32'd0);
        check("b2b_end_cnt_clr",  32'(CNT_CLR),  32'd0);
        check("b2b_meas_cnt_2",   32'(MEAS_CNT), 32'd2);
        check("b2b_result_2",     32'(RESULT),   32'h001234);

        // ---------------- single START pulse ----------------
        CNT_Q = 24'h000050;
        START = 1'b1;
        step();                                   // k = 1
        check("pulse_clr_k1", 32'(CNT_CLR), 32'd1);
        START = 1'b0;
        for (int k = 2; k <= 13; k++) step();
        check("pulse_valid_k13", 32'(VALID), 32'd0);
        step();                                   // k = 14
        check("pulse_valid_k14", 32'(VALID), 32'd1);
        step();                                   // k = 15
        check("pulse_busy_k15",  32'(BUSY),     32'd0);
        check("pulse_result",    32'(RESULT),   32'h000050);
        check("pulse_meas_cnt",  32'(MEAS_CNT), 32'd3);
        for (int k = 16; k <= 20; k++) begin
            step();
            check($sformatf("pulse_idle_busy_k%0d", k), 32'(BUSY),    32'd0);
            check($sformatf("pulse_idle_clr_k%0d", k),  32'(CNT_CLR), 32'd0);
        end

        // ---------------- ABORT in the 4th GATE cycle ----------------
        CNT_Q = 24'h000077;
        START = 1'b1;
        for (int k = 1; k <= 6; k++) step();      // k = 6 is GATE cycle 4
        check("abort_ena_before", 32'(CNT_ENA), 32'd1);
        ABORT = 1'b1;
        step();
        check("abort_ena_after",  32'(CNT_ENA),  32'd0);
        check("abort_busy",       32'(BUSY),     32'd0);
        check("abort_valid",      32'(VALID),    32'd0);
        check("abort_result",     32'(RESULT),   32'h000050);
        check("abort_meas_cnt",   32'(MEAS_CNT), 32'd3);
        // ABORT and START both high in IDLE: stay in IDLE.
        step();
        check("abort_start_idle_busy", 32'(BUSY),    32'd0);
        check("abort_start_idle_clr",  32'(CNT_CLR), 32'd0);
        ABORT = 1'b0;
        START = 1'b0;
        step();
        check("post_abort_busy", 32'(BUSY), 32'd0);

        // ---------------- CLR during SETTLE ----------------
        START = 1'b1;
        for (int k = 1; k <= 12; k++) step();     // k = 12 is in SETTLE
        check("settle_busy",   32'(BUSY),    32'd1);
        check("settle_ena",    32'(CNT_ENA), 32'd0);
        check("settle_result", 32'(RESULT),  32'h000050);
        CLR = 1'b1;
        step();
        check("clr_mid_cnt_clr",  32'(CNT_CLR),  32'd0);
        check("clr_mid_cnt_ena",  32'(CNT_ENA),  32'd0);
        check("clr_mid_valid",    32'(VALID),    32'd0);
        check("clr_mid_busy",     32'(BUSY),     32'd0);
        check("clr_mid_result",   32'(RESULT),   32'h0);
        check("clr_mid_meas_cnt", 32'(MEAS_CNT), 32'd0);
        CLR   = 1'b0;
        START = 1'b0;
        step();

`ifdef FREQ_GATE_CTRL_BCD_CHECK_EN
        // ---------------- illegal BCD digit, then a legal value ----------------
        CNT_Q = 24'h00A123;
        START = 1'b1;
        for (int k = 1; k <= 14; k++) step();
        check("bcd_bad_valid", 32'(VALID), 32'd0);
        step();                                   // k = 15
        check("bcd_err_set",      32'(BCD_ERR),  32'd1);
        check("bcd_bad_result",   32'(RESULT),   32'h0);
        check("bcd_bad_meas_cnt", 32'(MEAS_CNT), 32'd0);
        CNT_Q = 24'h000999;
        for (int k = 16; k <= 28; k++) step();
        check("bcd_good_valid", 32'(VALID), 32'd1);
        START = 1'b0;
        step();
        check("bcd_err_clear",     32'(BCD_ERR),  32'd0);
        check("bcd_good_result",   32'(RESULT),   32'h000999);
        check("bcd_good_meas_cnt", 32'(MEAS_CNT), 32'd1);
`endif

        // ---------------- 256 measurements, MEAS_CNT wrap ----------------
        CLR = 1'b1;
        step();
        CLR   = 1'b0;
        CNT_Q = 24'h000321;
        START = 1'b1;
        n_valid = 0;
        for (int k = 1; k <= 256 * 14 + 1; k++) begin
            step();
            if (VALID) n_valid++;
            if (k == 255 * 14 + 1) check("wrap_meas_cnt_255", 32'(MEAS_CNT), 32'd255);
            if (k == 256 * 14)     check("wrap_valid_256",    32'(VALID),    32'd1);
            if (k == 256 * 14 + 1) check("wrap_meas_cnt_0",   32'(MEAS_CNT), 32'd0);
        end
        check("wrap_valid_count", 32'(n_valid), 32'd256);
        check("wrap_result",      32'(RESULT),  32'h000321);
        START = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
